// File: rtl/pic_8259_pkg.sv
// Shared types and bit positions for the 8259A bus front end.
package pic_8259_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned CMD_D4_BIT = 4;
  localparam int unsigned CMD_D3_BIT = 3;
  localparam int unsigned SNGL_BIT   = 1;
  localparam int unsigned IC4_BIT    = 0;

  typedef enum logic [2:0] {UNINIT, ICW2, ICW3, ICW4, READY} init_state_t;

  typedef struct packed {
    logic                  a0;
    logic [DATA_WIDTH-1:0] data;
  } bus_sample_t;

  typedef struct packed {
    logic write;
    logic icw1;
    logic icw2_4;
    logic ocw1;
    logic ocw2;
    logic ocw3;
  } strobe_t;

  // Next expected ICW: 0 = none, ICW2/3/4 encoded 1/2/3.
  function automatic logic [1:0] icw_code(input init_state_t s);
    case (s)
      ICW2:    icw_code = 2'd1;
      ICW3:    icw_code = 2'd2;
      ICW4:    icw_code = 2'd3;
      default: icw_code = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pic_bus_sync.sv
// CPU pin input stage: s1/s2 sample registers, WR# rising-edge detect and read level.
// Build option PIC_BUS_INPUT_SYNC_EN adds a 2-flop synchronizer ahead of s1.
module pic_bus_sync
  import pic_8259_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  chip_select_n,
  input  logic                  read_enable_n,
  input  logic                  write_enable_n,
  input  logic                  address,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic                  write_accept_c,
  output bus_sample_t           write_sample,
  output logic                  read
);

  logic        cs_pre, rd_pre, wr_pre;
  bus_sample_t samp_pre;

`ifdef PIC_BUS_INPUT_SYNC_EN
  logic [1:0]  cs_sync, rd_sync, wr_sync;
  bus_sample_t samp_d1, samp_d2;

  // Control pins synchronized; A0/D delayed by the same two clocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync <= 2'b11;
      rd_sync <= 2'b11;
      wr_sync <= 2'b11;
      samp_d1 <= '0;
      samp_d2 <= '0;
    end else begin
      cs_sync <= {cs_sync[0], chip_select_n};
      rd_sync <= {rd_sync[0], read_enable_n};
      wr_sync <= {wr_sync[0], write_enable_n};
      samp_d1 <= '{a0: address, data: data_bus_in};
      samp_d2 <= samp_d1;
    end
  end

  assign cs_pre   = cs_sync[1];
  assign rd_pre   = rd_sync[1];
  assign wr_pre   = wr_sync[1];
  assign samp_pre = samp_d2;
`else
  assign cs_pre   = chip_select_n;
  assign rd_pre   = read_enable_n;
  assign wr_pre   = write_enable_n;
  assign samp_pre = '{a0: address, data: data_bus_in};
`endif

  logic        cs_s1, cs_s2, wr_s1, wr_s2;
  bus_sample_t samp_s1;

  // read is registered alongside s1, so it equals the s1 decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1        <= 1'b1;
      cs_s2        <= 1'b1;
      wr_s1        <= 1'b1;
      wr_s2        <= 1'b1;
      samp_s1      <= '0;
      write_sample <= '0;
      read         <= 1'b0;
    end else begin
      cs_s1        <= cs_pre;
      cs_s2        <= cs_s1;
      wr_s1        <= wr_pre;
      wr_s2        <= wr_s1;
      samp_s1      <= samp_pre;
      write_sample <= samp_s1;
      read         <= !cs_pre && !rd_pre && wr_pre;
    end
  end

  // CS# from s2 so a deassert coincident with the WR# rise still accepts.
  assign write_accept_c = !wr_s2 && wr_s1 && !cs_s2;

endmodule

// File: rtl/pic_bus_control.sv
// 8259A bus front end: write strobes, read level, ICW sequence tracking and OCW decode.
// Optional input synchronizer selected by PIC_BUS_INPUT_SYNC_EN (see pic_bus_sync).
module pic_bus_control
  import pic_8259_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  chip_select_n,
  input  logic                  read_enable_n,
  input  logic                  write_enable_n,
  input  logic                  address,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic                  write,
  output logic                  read,
  output logic                  write_initial_command_word_1,
  output logic                  write_initial_command_word_2_4,
  output logic                  write_operation_control_word_1,
  output logic                  write_operation_control_word_2,
  output logic                  write_operation_control_word_3,
  output logic                  init_ready,
  output logic [1:0]            icw_expected
);

  logic        write_accept_c;
  bus_sample_t ws;

  pic_bus_sync u_sync (
    .clock          (clock),
    .reset_n        (reset_n),
    .chip_select_n  (chip_select_n),
    .read_enable_n  (read_enable_n),
    .write_enable_n (write_enable_n),
    .address        (address),
    .data_bus_in    (data_bus_in),
    .write_accept_c (write_accept_c),
    .write_sample   (ws),
    .read           (read)
  );

  init_state_t           state, state_d;
  strobe_t               strobe_q, strobe_d;
  logic                  sngl, sngl_d, ic4, ic4_d;
  logic [DATA_WIDTH-1:0] bus_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= UNINIT;
      strobe_q          <= '0;
      sngl              <= 1'b0;
      ic4               <= 1'b0;
      internal_data_bus <= '0;
      init_ready        <= 1'b0;
      icw_expected      <= 2'd0;
    end else begin
      state             <= state_d;
      strobe_q          <= strobe_d;
      sngl              <= sngl_d;
      ic4               <= ic4_d;
      internal_data_bus <= bus_d;
      init_ready        <= (state_d == READY);
      icw_expected      <= icw_code(state_d);
    end
  end

  // Write decode and init sequence; ignored writes leave everything untouched.
  always_comb begin
    state_d  = state;
    strobe_d = '0;
    sngl_d   = sngl;
    ic4_d    = ic4;
    bus_d    = internal_data_bus;
    if (write_accept_c) begin
      if (!ws.a0 && ws.data[CMD_D4_BIT]) begin
        strobe_d.icw1 = 1'b1;
        sngl_d        = ws.data[SNGL_BIT];
        ic4_d         = ws.data[IC4_BIT];
        state_d       = ICW2;
      end else if (ws.a0) begin
        case (state)
          ICW2: begin
            strobe_d.icw2_4 = 1'b1;
            state_d = !sngl ? ICW3 : (ic4 ? ICW4 : READY);
          end
          ICW3: begin
            strobe_d.icw2_4 = 1'b1;
            state_d = ic4 ? ICW4 : READY;
          end
          ICW4: begin
            strobe_d.icw2_4 = 1'b1;
            state_d = READY;
          end
          READY:   strobe_d.ocw1 = 1'b1;
          default: ;
        endcase
      end else if (state == READY) begin
        if (ws.data[CMD_D3_BIT]) strobe_d.ocw3 = 1'b1;
        else                     strobe_d.ocw2 = 1'b1;
      end
      if (strobe_d != '0) begin
        strobe_d.write = 1'b1;
        bus_d          = ws.data;
      end
    end
  end

  assign write                          = strobe_q.write;
  assign write_initial_command_word_1   = strobe_q.icw1;
  assign write_initial_command_word_2_4 = strobe_q.icw2_4;
  assign write_operation_control_word_1 = strobe_q.ocw1;
  assign write_operation_control_word_2 = strobe_q.ocw2;
  assign write_operation_control_word_3 = strobe_q.ocw3;

endmodule

// File: tb/tb_pic_bus_control.sv
// Directed self-checking bench for pic_bus_control.
module tb_pic_bus_control;

`ifdef PIC_BUS_INPUT_SYNC_EN
  localparam int LAT = 4;
  localparam int RLAT = 3;
`else
  localparam int LAT = 2;
  localparam int RLAT = 1;
`endif

  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_ICW1  = 6'b110000;
  localparam logic [5:0] S_ICW24 = 6'b101000;
  localparam logic [5:0] S_OCW1  = 6'b100100;
  localparam logic [5:0] S_OCW2  = 6'b100010;
  localparam logic [5:0] S_OCW3  = 6'b100001;

  typedef struct {
    logic       a;
    logic [7:0] d;
    logic [5:0] s;
    logic [7:0] bus;
    logic [1:0] icw;
    logic       rdy;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       chip_select_n = 1'b1;
  logic       read_enable_n = 1'b1;
  logic       write_enable_n = 1'b1;
  logic       address = 1'b0;
  logic [7:0] data_bus_in = 8'h00;
  logic [7:0] internal_data_bus;
  logic       write, read, icw1, icw24, ocw1, ocw2, ocw3, init_ready;
  logic [1:0] icw_expected;
  wire  [5:0] strb = {write, icw1, icw24, ocw1, ocw2, ocw3};

  int checks = 0;
  int errors = 0;

  pic_bus_control dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .chip_select_n                  (chip_select_n),
    .read_enable_n                  (read_enable_n),
    .write_enable_n                 (write_enable_n),
    .address                        (address),
    .data_bus_in                    (data_bus_in),
    .internal_data_bus              (internal_data_bus),
    .write                          (write),
    .read                           (read),
    .write_initial_command_word_1   (icw1),
    .write_initial_command_word_2_4 (icw24),
    .write_operation_control_word_1 (ocw1),
    .write_operation_control_word_2 (ocw2),
    .write_operation_control_word_3 (ocw3),
    .init_ready                     (init_ready),
    .icw_expected                   (icw_expected)
  );

  always #5 clock = ~clock;

  // One bus write; returns strobes at the expected latency and one cycle later.
  task automatic bus_write(input logic a, input logic [7:0] d, input logic cs_low,
                           input logic cs_rel_with_wr, output logic [5:0] s,
                           output logic [5:0] s_next);
    @(negedge clock);
    chip_select_n = ~cs_low; address = a; data_bus_in = d; write_enable_n = 1'b0;
    @(negedge clock);
    write_enable_n = 1'b1;
    if (cs_rel_with_wr) chip_select_n = 1'b1;
    repeat (LAT) @(posedge clock);
    #1 s = strb;
    @(posedge clock);
    #1 s_next = strb;
    @(negedge clock);
    chip_select_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({strb, read, internal_data_bus, init_ready, icw_expected} !== 18'h0) begin
      errors++;
      $display("FAIL reset outputs: got strb=%b read=%b bus=%h rdy=%b icw=%0d want all zero",
               strb, read, internal_data_bus, init_ready, icw_expected);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_before_init();
    vec_t tbl[2];
    logic [5:0] s, sn;
    tbl = '{'{1'b1, 8'hAA, S_NONE, 8'h00, 2'd0, 1'b0},
            '{1'b0, 8'h20, S_NONE, 8'h00, 2'd0, 1'b0}};
    foreach (tbl[i]) begin
      bus_write(tbl[i].a, tbl[i].d, 1'b1, 1'b0, s, sn);
      checks++;
      if (s !== tbl[i].s || sn !== S_NONE) begin
        errors++; $display("FAIL before_init[%0d] strobes: got %b/%b want %b/000000", i, s, sn, tbl[i].s);
      end
      checks++;
      if ({internal_data_bus, icw_expected, init_ready} !== {tbl[i].bus, tbl[i].icw, tbl[i].rdy}) begin
        errors++; $display("FAIL before_init[%0d] state: got bus=%h icw=%0d rdy=%b want bus=%h icw=%0d rdy=%b",
                           i, internal_data_bus, icw_expected, init_ready, tbl[i].bus, tbl[i].icw, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_single();
    vec_t tbl[3];
    logic [5:0] s, sn;
    tbl = '{'{1'b0, 8'h17, S_ICW1,  8'h17, 2'd1, 1'b0},
            '{1'b1, 8'hF8, S_ICW24, 8'hF8, 2'd3, 1'b0},
            '{1'b1, 8'h01, S_ICW24, 8'h01, 2'd0, 1'b1}};
    foreach (tbl[i]) begin
      bus_write(tbl[i].a, tbl[i].d, 1'b1, 1'b0, s, sn);
      checks++;
      if (s !== tbl[i].s) begin
        errors++; $display("FAIL single[%0d] strobes: got %b want %b", i, s, tbl[i].s);
      end
      checks++;
      if (sn !== S_NONE) begin
        errors++; $display("FAIL single[%0d] pulse width: got %b want 000000", i, sn);
      end
      checks++;
      if ({internal_data_bus, icw_expected, init_ready} !== {tbl[i].bus, tbl[i].icw, tbl[i].rdy}) begin
        errors++; $display("FAIL single[%0d] state: got bus=%h icw=%0d rdy=%b want bus=%h icw=%0d rdy=%b",
                           i, internal_data_bus, icw_expected, init_ready, tbl[i].bus, tbl[i].icw, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_ocw();
    vec_t tbl[3];
    logic [5:0] s, sn;
    tbl = '{'{1'b0, 8'h20, S_OCW2, 8'h20, 2'd0, 1'b1},
            '{1'b0, 8'h08, S_OCW3, 8'h08, 2'd0, 1'b1},
            '{1'b1, 8'hC3, S_OCW1, 8'hC3, 2'd0, 1'b1}};
    foreach (tbl[i]) begin
      bus_write(tbl[i].a, tbl[i].d, 1'b1, 1'b0, s, sn);
      checks++;
      if (s !== tbl[i].s || sn !== S_NONE) begin
        errors++; $display("FAIL ocw[%0d] strobes: got %b/%b want %b/000000", i, s, sn, tbl[i].s);
      end
      checks++;
      if ({internal_data_bus, icw_expected, init_ready} !== {tbl[i].bus, tbl[i].icw, tbl[i].rdy}) begin
        errors++; $display("FAIL ocw[%0d] state: got bus=%h icw=%0d rdy=%b want bus=%h icw=%0d rdy=%b",
                           i, internal_data_bus, icw_expected, init_ready, tbl[i].bus, tbl[i].icw, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_read();
    logic [5:0] s, sn;
    @(negedge clock);
    chip_select_n = 1'b0; read_enable_n = 1'b0; address = 1'b1; data_bus_in = 8'h55;
    repeat (RLAT) @(posedge clock);
    #1;
    checks++;
    if (read !== 1'b1) begin errors++; $display("FAIL read level: got %b want 1", read); end
    @(negedge clock);
    write_enable_n = 1'b0;
    repeat (RLAT) @(posedge clock);
    #1;
    checks++;
    if (read !== 1'b0) begin errors++; $display("FAIL read with WR low: got %b want 0", read); end
    @(negedge clock);
    write_enable_n = 1'b1; read_enable_n = 1'b1;
    repeat (LAT) @(posedge clock);
    #1;
    checks++;
    if (strb !== S_OCW1 || internal_data_bus !== 8'h55) begin
      errors++; $display("FAIL read+write wins: got strb=%b bus=%h want %b bus=55", strb, internal_data_bus, S_OCW1);
    end
    @(negedge clock);
    chip_select_n = 1'b1;
    bus_write(1'b1, 8'h99, 1'b0, 1'b0, s, sn);
    checks++;
    if (s !== S_NONE || internal_data_bus !== 8'h55) begin
      errors++; $display("FAIL cs_high write: got strb=%b bus=%h want 000000 bus=55", s, internal_data_bus);
    end
    bus_write(1'b1, 8'h3C, 1'b1, 1'b1, s, sn);
    checks++;
    if (s !== S_OCW1 || sn !== S_NONE || internal_data_bus !== 8'h3C) begin
      errors++; $display("FAIL cs_release_with_wr: got strb=%b/%b bus=%h want %b/000000 bus=3c",
                         s, sn, internal_data_bus, S_OCW1);
    end
  endtask

  task automatic test_cascade();
    vec_t tbl[5];
    logic [5:0] s, sn;
    tbl = '{'{1'b0, 8'hF5, S_ICW1,  8'hF5, 2'd1, 1'b0},
            '{1'b1, 8'hFF, S_ICW24, 8'hFF, 2'd2, 1'b0},
            '{1'b1, 8'hFF, S_ICW24, 8'hFF, 2'd3, 1'b0},
            '{1'b1, 8'h00, S_ICW24, 8'h00, 2'd0, 1'b1},
            '{1'b1, 8'h00, S_OCW1,  8'h00, 2'd0, 1'b1}};
    foreach (tbl[i]) begin
      bus_write(tbl[i].a, tbl[i].d, 1'b1, 1'b0, s, sn);
      checks++;
      if (s !== tbl[i].s || sn !== S_NONE) begin
        errors++; $display("FAIL cascade[%0d] strobes: got %b/%b want %b/000000", i, s, sn, tbl[i].s);
      end
      checks++;
      if ({internal_data_bus, icw_expected, init_ready} !== {tbl[i].bus, tbl[i].icw, tbl[i].rdy}) begin
        errors++; $display("FAIL cascade[%0d] state: got bus=%h icw=%0d rdy=%b want bus=%h icw=%0d rdy=%b",
                           i, internal_data_bus, icw_expected, init_ready, tbl[i].bus, tbl[i].icw, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_restart();
    vec_t tbl[5];
    logic [5:0] s, sn;
    tbl = '{'{1'b0, 8'hF5, S_ICW1,  8'hF5, 2'd1, 1'b0},
            '{1'b1, 8'hFF, S_ICW24, 8'hFF, 2'd2, 1'b0},
            '{1'b0, 8'h13, S_ICW1,  8'h13, 2'd1, 1'b0},
            '{1'b1, 8'hA5, S_ICW24, 8'hA5, 2'd3, 1'b0},
            '{1'b0, 8'h08, S_NONE,  8'hA5, 2'd3, 1'b0}};
    foreach (tbl[i]) begin
      bus_write(tbl[i].a, tbl[i].d, 1'b1, 1'b0, s, sn);
      checks++;
      if (s !== tbl[i].s || sn !== S_NONE) begin
        errors++; $display("FAIL restart[%0d] strobes: got %b/%b want %b/000000", i, s, sn, tbl[i].s);
      end
      checks++;
      if ({internal_data_bus, icw_expected, init_ready} !== {tbl[i].bus, tbl[i].icw, tbl[i].rdy}) begin
        errors++; $display("FAIL restart[%0d] state: got bus=%h icw=%0d rdy=%b want bus=%h icw=%0d rdy=%b",
                           i, internal_data_bus, icw_expected, init_ready, tbl[i].bus, tbl[i].icw, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] s, sn;
    bus_write(1'b0, 8'h17, 1'b1, 1'b0, s, sn);
    bus_write(1'b1, 8'hF8, 1'b1, 1'b0, s, sn);
    checks++;
    if (icw_expected !== 2'd3) begin
      errors++; $display("FAIL reset_mid pre: got icw=%0d want 3", icw_expected);
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({strb, read, internal_data_bus, init_ready, icw_expected} !== 18'h0) begin
      errors++; $display("FAIL reset_mid outputs: got strb=%b bus=%h rdy=%b icw=%0d want all zero",
                         strb, internal_data_bus, init_ready, icw_expected);
    end
    @(negedge clock);
    reset_n = 1'b1;
    bus_write(1'b1, 8'h77, 1'b1, 1'b0, s, sn);
    checks++;
    if (s !== S_NONE || internal_data_bus !== 8'h00 || icw_expected !== 2'd0) begin
      errors++; $display("FAIL reset_mid ignore: got strb=%b bus=%h icw=%0d want 000000 bus=00 icw=0",
                         s, internal_data_bus, icw_expected);
    end
  endtask

  initial begin
    test_reset();
    test_before_init();
    test_single();
    test_ocw();
    test_read();
    test_cascade();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
